// File: rtl/segre_pkg.sv
// Shared sizes and types for the dcache memory-side port.
// Holds address/word/lane geometry, memop sizes, store-buffer entry and mmu port state.
package segre_pkg;

  localparam int ADDR_SIZE         = 32;
  localparam int WORD_SIZE         = 32;
  localparam int DCACHE_BYTE_SIZE  = 4;
  localparam int DCACHE_INDEX_SIZE = 2;
  localparam int DCACHE_LANE_SIZE  = 128;
  localparam int DCACHE_TAG_SIZE   =
    ADDR_SIZE - DCACHE_BYTE_SIZE - DCACHE_INDEX_SIZE;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } memop_data_type_e;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
    memop_data_type_e     mtype;
  } stb_entry_t;

  typedef enum logic [1:0] {
    MMU_IDLE,
    MMU_DRAIN,
    MMU_FILL,
    MMU_WRITE
  } mmu_state_e;

endpackage

// File: rtl/segre_store_buffer.sv
// In-order write-through store FIFO of stb_entry_t.
// Ports: push/data in, pop, head out, full/empty from the registered count.
module segre_store_buffer
  import segre_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rsn_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  stb_entry_t data_i,
  output stb_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PW = $clog2(DEPTH);

  stb_entry_t     mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW:0]    cnt_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  // A push into a full buffer is refused even if a pop frees a slot.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(do_push)
                     - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/segre_dcache_mmu_port.sv
// Memory-side port of the dcache: line fills and write-through store drain.
// Ports: dc_miss_*, st_* in; mmu_* lane write out; mem_* single-outstanding bus.
module segre_dcache_mmu_port
  import segre_pkg::*;
#(
  parameter int STB_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         dc_miss_i,
  input  logic [ADDR_SIZE-1:0]         dc_miss_addr_i,
  input  logic                         st_valid_i,
  input  logic [ADDR_SIZE-1:0]         st_addr_i,
  input  logic [WORD_SIZE-1:0]         st_data_i,
  input  memop_data_type_e             st_type_i,
  output logic                         st_ready_o,
  output logic                         stb_empty_o,
  output logic                         mmu_wr_data_o,
  output logic [DCACHE_INDEX_SIZE-1:0] mmu_index_o,
  output logic [DCACHE_TAG_SIZE-1:0]   mmu_tag_o,
  output logic [DCACHE_LANE_SIZE-1:0]  mmu_data_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  output logic [WORD_SIZE-1:0]         mem_wdata_o,
  output memop_data_type_e             mem_type_o,
  input  logic                         mem_ready_i,
  input  logic [DCACHE_LANE_SIZE-1:0]  mem_rdata_i
);

  localparam logic [ADDR_SIZE-1:0] LINE_MASK =
    ~ADDR_SIZE'((1 << DCACHE_BYTE_SIZE) - 1);

  mmu_state_e                          state_q;
  stb_entry_t                          st_entry;
  stb_entry_t                          head;
  logic                                stb_full;
  logic                                stb_empty;
  logic                                stb_pop;
  logic [ADDR_SIZE-1:DCACHE_BYTE_SIZE] line_q;
  logic [DCACHE_LANE_SIZE-1:0]         lane_q;
  logic                                wr_q;
  logic                                req_q;
  logic                                we_q;
  logic [ADDR_SIZE-1:0]                addr_q;
  logic [WORD_SIZE-1:0]                wdata_q;
  memop_data_type_e                    type_q;

  assign st_entry = '{addr:  st_addr_i,
                      data:  st_data_i,
                      mtype: st_type_i};
  assign stb_pop  = (state_q == MMU_DRAIN) && mem_ready_i;

  segre_store_buffer #(
    .DEPTH (STB_DEPTH)
  ) u_stb (
    .clk_i   (clk_i),
    .rsn_i   (rsn_i),
    .push_i  (st_valid_i),
    .pop_i   (stb_pop),
    .data_i  (st_entry),
    .head_o  (head),
    .full_o  (stb_full),
    .empty_o (stb_empty)
  );

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= MMU_IDLE;
      line_q  <= '0;
      lane_q  <= '0;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= WORD;
    end else begin
      wr_q <= 1'b0;
      unique case (state_q)
        MMU_IDLE: begin
          // Stores go first so a fill never reads stale memory.
          if (!stb_empty) begin
            state_q <= MMU_DRAIN;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= head.addr;
            wdata_q <= head.data;
            type_q  <= head.mtype;
          end else if (dc_miss_i) begin
            state_q <= MMU_FILL;
            line_q  <= dc_miss_addr_i[ADDR_SIZE-1:DCACHE_BYTE_SIZE];
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= dc_miss_addr_i & LINE_MASK;
            wdata_q <= '0;
            type_q  <= WORD;
          end
        end
        MMU_DRAIN: begin
          if (mem_ready_i) begin
            state_q <= MMU_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end
        end
        MMU_FILL: begin
          if (mem_ready_i) begin
            state_q <= MMU_WRITE;
            req_q   <= 1'b0;
            lane_q  <= mem_rdata_i;
            wr_q    <= 1'b1;
          end
        end
        MMU_WRITE: state_q <= MMU_IDLE;
        default:   state_q <= MMU_IDLE;
      endcase
    end
  end

  assign st_ready_o    = !stb_full;
  assign stb_empty_o   = stb_empty;
  assign mmu_wr_data_o = wr_q;
  assign mmu_index_o   = line_q[DCACHE_BYTE_SIZE +: DCACHE_INDEX_SIZE];
  assign mmu_tag_o     = line_q[ADDR_SIZE-1 -: DCACHE_TAG_SIZE];
  assign mmu_data_o    = lane_q;
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_type_o    = type_q;

endmodule

// File: tb/tb_segre_dcache_mmu_port.sv
// Directed plus randomized bench for segre_dcache_mmu_port.
// A queue of pushed stores and lane arithmetic give the expected bus traffic.
module tb_segre_dcache_mmu_port;
  import segre_pkg::*;

  logic                         clk = 1'b0;
  logic                         rsn;
  logic                         dc_miss;
  logic [ADDR_SIZE-1:0]         dc_miss_addr;
  logic                         st_valid;
  logic [ADDR_SIZE-1:0]         st_addr;
  logic [WORD_SIZE-1:0]         st_data;
  memop_data_type_e             st_type;
  logic                         st_ready;
  logic                         stb_empty;
  logic                         mmu_wr;
  logic [DCACHE_INDEX_SIZE-1:0] mmu_index;
  logic [DCACHE_TAG_SIZE-1:0]   mmu_tag;
  logic [DCACHE_LANE_SIZE-1:0]  mmu_data;
  logic                         mem_req;
  logic                         mem_we;
  logic [ADDR_SIZE-1:0]         mem_addr;
  logic [WORD_SIZE-1:0]         mem_wdata;
  memop_data_type_e             mem_type;
  logic                         mem_ready;
  logic [DCACHE_LANE_SIZE-1:0]  mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      d;
    memop_data_type_e t;
  } st_t;

  st_t model_q[$];

  segre_dcache_mmu_port #(.STB_DEPTH(4)) dut (
    .clk_i          (clk),
    .rsn_i          (rsn),
    .dc_miss_i      (dc_miss),
    .dc_miss_addr_i (dc_miss_addr),
    .st_valid_i     (st_valid),
    .st_addr_i      (st_addr),
    .st_data_i      (st_data),
    .st_type_i      (st_type),
    .st_ready_o     (st_ready),
    .stb_empty_o    (stb_empty),
    .mmu_wr_data_o  (mmu_wr),
    .mmu_index_o    (mmu_index),
    .mmu_tag_o      (mmu_tag),
    .mmu_data_o     (mmu_data),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_type_o     (mem_type),
    .mem_ready_i    (mem_ready),
    .mem_rdata_i    (mem_rdata)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_store(input logic [31:0] a,
                            input logic [31:0] d,
                            input memop_data_type_e t);
    st_t e;
    e.a = a; e.d = d; e.t = t;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_type  = t;
    chk("st_ready_at_push", st_ready, 1);
    model_q.push_back(e);
    tick();
    st_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("mem_req_seen", mem_req, 1);
  endtask

  task automatic serve_store(input int lat);
    st_t e;
    if (model_q.size() == 0) begin
      chk("model_has_store", 0, 1);
      return;
    end
    e = model_q.pop_front();
    wait_req();
    chk("drain_we", mem_we, 1);
    chk("drain_addr", mem_addr, e.a);
    chk("drain_wdata", mem_wdata, e.d);
    chk("drain_type", mem_type, e.t);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("drain_hold_req", mem_req, 1);
      chk("drain_hold_addr", mem_addr, e.a);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("drain_req_drop", mem_req, 0);
  endtask

  task automatic serve_fill(input logic [31:0] a,
                            input logic [127:0] lane,
                            input int lat);
    wait_req();
    chk("fill_we", mem_we, 0);
    chk("fill_addr", mem_addr, a - (a % 16));
    chk("fill_type", mem_type, WORD);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("fill_hold_addr", mem_addr, a - (a % 16));
      chk("fill_no_wr", mmu_wr, 0);
    end
    mem_rdata = lane;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rdata = ~lane;
    chk("fill_wr_pulse", mmu_wr, 1);
    chk("fill_lane", mmu_data, lane);
    chk("fill_index", mmu_index, (a / 16) % 4);
    chk("fill_tag", mmu_tag, a / 64);
    chk("fill_req_drop", mem_req, 0);
    tick();
    chk("fill_wr_one_cycle", mmu_wr, 0);
    dc_miss = 1'b0;
  endtask

  initial begin
    logic [31:0]      ra;
    logic [31:0]      rd;
    memop_data_type_e rt;
    int               n;
    bit               miss;
    logic [31:0]      maddr;

    rsn          = 1'b0;
    dc_miss      = 1'b0;
    dc_miss_addr = '0;
    st_valid     = 1'b0;
    st_addr      = '0;
    st_data      = '0;
    st_type      = WORD;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    tick();
    tick();

    chk("rst_st_ready", st_ready, 1);
    chk("rst_stb_empty", stb_empty, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mmu_wr", mmu_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mmu_data", mmu_data, 0);
    chk("rst_mmu_index", mmu_index, 0);
    chk("rst_mmu_tag", mmu_tag, 0);
    rsn = 1'b1;
    tick();

    // Line miss with a three-cycle memory.
    dc_miss      = 1'b1;
    dc_miss_addr = 32'h0000_1234;
    tick();
    chk("miss_req_latency", mem_req, 1);
    chk("miss_addr_aligned", mem_addr, 32'h0000_1230);
    serve_fill(32'h0000_1234,
               128'h01234567_89abcdef_0badf00d_deadbeef, 2);

    // Four back-to-back word stores into a stalled memory.
    push_store(32'h0000_0100, 32'h1111_0001, WORD);
    push_store(32'h0000_0104, 32'h2222_0002, WORD);
    push_store(32'h0000_0108, 32'h3333_0003, WORD);
    push_store(32'h0000_010c, 32'h4444_0004, WORD);
    chk("full_st_ready", st_ready, 0);
    chk("full_not_empty", stb_empty, 0);
    for (int i = 0; i < 4; i++) serve_store(i);
    chk("drained_empty", stb_empty, 1);

    // Pending store wins over a miss raised behind it.
    push_store(32'h0000_2000, 32'h1111_2222, WORD);
    dc_miss      = 1'b1;
    dc_miss_addr = 32'h0000_5678;
    serve_store(2);
    serve_fill(32'h0000_5678,
               128'hcafef00d_12345678_9abcdef0_0f0f0f0f, 1);

    // Byte store.
    push_store(32'h0000_0103, 32'h0000_00ab, BYTE);
    serve_store(1);

    // Reset in the middle of a fill with a store queued.
    dc_miss      = 1'b1;
    dc_miss_addr = 32'h8000_0040;
    tick();
    chk("rstfill_req", mem_req, 1);
    st_valid = 1'b1;
    st_addr  = 32'h0000_0200;
    st_data  = 32'h7777_7777;
    st_type  = WORD;
    tick();
    st_valid = 1'b0;
    chk("rstfill_queued", stb_empty, 0);
    rsn = 1'b0;
    #1;
    chk("rstfill_req_drop", mem_req, 0);
    chk("rstfill_flush", stb_empty, 1);
    chk("rstfill_ready", st_ready, 1);
    dc_miss = 1'b0;
    tick();
    rsn = 1'b1;
    tick();
    mem_rdata = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ready_no_wr", mmu_wr, 0);
      chk("late_ready_idle", mem_req, 0);
      tick();
    end
    chk("late_ready_empty", stb_empty, 1);

    // Push into a full buffer on the cycle it pops.
    push_store(32'h0000_0300, 32'haaaa_0001, WORD);
    push_store(32'h0000_0304, 32'haaaa_0002, HALF);
    push_store(32'h0000_0308, 32'haaaa_0003, WORD);
    push_store(32'h0000_030c, 32'haaaa_0004, BYTE);
    wait_req();
    chk("popfull_head_addr", mem_addr, model_q[0].a);
    chk("popfull_head_data", mem_wdata, model_q[0].d);
    void'(model_q.pop_front());
    st_valid  = 1'b1;
    st_addr   = 32'hdead_0000;
    st_data   = 32'h5a5a_5a5a;
    st_type   = WORD;
    mem_ready = 1'b1;
    chk("popfull_refused", st_ready, 0);
    tick();
    st_valid  = 1'b0;
    mem_ready = 1'b0;
    chk("popfull_count3", st_ready, 1);
    chk("popfull_not_empty", stb_empty, 0);
    for (int i = 0; i < 3; i++) serve_store(1);
    tick();
    tick();
    chk("popfull_no_extra", mem_req, 0);
    chk("popfull_empty", stb_empty, 1);

    // Random bursts of stores, optionally followed by a miss.
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        rt = memop_data_type_e'($urandom_range(0, 2));
        rd = $urandom;
        if (rt == BYTE) rd = rd % 256;
        if (rt == HALF) rd = rd % 65536;
        ra = $urandom;
        push_store(ra, rd, rt);
      end
      miss = 1'($urandom_range(0, 1));
      maddr = $urandom;
      if (miss) begin
        dc_miss      = 1'b1;
        dc_miss_addr = maddr;
      end
      for (int i = 0; i < n; i++) serve_store($urandom_range(0, 4));
      if (miss)
        serve_fill(maddr, {$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 4));
      chk("rand_empty", stb_empty, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/segre_dcache_mmu_port.md
# segre_dcache_mmu_port

Memory-side counterpart of the dcache data/tag arrays. It accepts line-miss requests from the dcache and fetches the full lane from memory, then delivers it to the arrays as a one-cycle lane write. It also owns the write-through path: a small store buffer absorbs store data and type coming out of the dcache and drains it to memory in order. It sits between the dcache and the shared memory port, with one outstanding memory transaction at a time.

## Interface
Parameters:
- STB_DEPTH, 4, store-buffer entries; power of two, ≥2

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  reset; asynchronous, active-low
- dc_miss_i  in  1  dcache line miss; level, held until fill delivered
- dc_miss_addr_i  in  ADDR_SIZE  miss byte address
- st_valid_i  in  1  write-through store valid
- st_addr_i  in  ADDR_SIZE  store byte address
- st_data_i  in  WORD_SIZE  store data, right-aligned
- st_type_i  in  memop_data_type_e  BYTE/HALF/WORD
- st_ready_o  out  1  store buffer can accept
- stb_empty_o  out  1  no pending stores
- mmu_wr_data_o  out  1  lane-write strobe to data array (one cycle)
- mmu_index_o  out  DCACHE_INDEX_SIZE  lane index for fill
- mmu_tag_o  out  DCACHE_TAG_SIZE  tag for fill
- mmu_data_o  out  DCACHE_LANE_SIZE  fill lane
- mem_req_o  out  1  memory request; level
- mem_we_o  out  1  1 = store, 0 = lane read
- mem_addr_o  out  ADDR_SIZE  request address
- mem_wdata_o  out  WORD_SIZE  store data
- mem_type_o  out  memop_data_type_e  store size (WORD on reads)
- mem_ready_i  in  1  one-cycle completion pulse
- mem_rdata_i  in  DCACHE_LANE_SIZE  read lane, valid with mem_ready_i

## Operation
- Store buffer: FIFO of {addr, data, type}. Push on st_valid_i && st_ready_o. st_ready_o = !full, from registered count; no push-on-full bypass. stb_empty_o = count==0.
- FSM states:
  - IDLE: if !stb_empty → DRAIN; else if dc_miss_i → latch dc_miss_addr_i, → FILL. Stores take priority, so memory always holds prior stores before a line is read.
  - DRAIN: mem_req_o=1, mem_we_o=1, addr/data/type from FIFO head. On mem_ready_i: pop and → IDLE.
  - FILL: mem_req_o=1, mem_we_o=0, mem_addr_o = latched address with low DCACHE_BYTE_SIZE bits zeroed. On mem_ready_i: capture mem_rdata_i and → WRITE.
  - WRITE: mmu_wr_data_o=1 with captured lane; index = addr[DCACHE_BYTE_SIZE +: DCACHE_INDEX_SIZE]; tag = top DCACHE_TAG_SIZE bits. → IDLE.
- mem_req_o and all mem_* outputs are stable from assertion until the mem_ready_i cycle inclusive.
- mem_ready_i is ignored in IDLE and WRITE.
- Pushes are accepted in every state, including the cycle of a pop; count is updated by push − pop.
- dc_miss_i is sampled only in IDLE. The dcache drops it the cycle after the mmu_wr_data_o pulse.

## Timing
- Reset values: state IDLE, FIFO empty, st_ready_o=1, stb_empty_o=1, mem_req_o=0, mem_we_o=0, mmu_wr_data_o=0, all data/address outputs 0.
- Miss, empty buffer: miss seen in IDLE at cycle 0 → mem_req_o high at cycle 1. mem_ready_i at cycle N → mmu_wr_data_o at N+1 → IDLE at N+2.
- Store: pushed at cycle 0 → visible at head cycle 1 → DRAIN mem_req_o at cycle 2 if IDLE at cycle 1. One memory latency per entry plus one IDLE cycle.
- Reset mid-transaction: immediate return to IDLE, FIFO flushed, mem_req_o dropped. A late mem_ready_i is ignored.
- Pointers wrap modulo STB_DEPTH; count is log2(STB_DEPTH)+1 bits.

## Structure
- Package segre_pkg holds ADDR_SIZE, WORD_SIZE, the DCACHE_* sizes, and memop_data_type_e.
- Add to the package: stb_entry_t {addr, data, type} and the mmu port state enum.
- Sub-module segre_store_buffer: a parameterised FIFO of stb_entry_t with push, pop, full, empty and head ports.

## Test plan
- Miss 0x0000_1234, memory returns lane 0x…DEADBEEF after 3 cycles → mem_addr_o=0x0000_1230; mmu_wr_data_o one cycle with that lane and index/tag of 0x1234.
- Push 4 WORD stores (STB_DEPTH=4) in consecutive cycles with memory stalled → st_ready_o low after the 4th; the stores drain in push order with matching addr/data/type.
- Store pending plus simultaneous miss → DRAIN completes before FILL's mem_req_o rises.
- BYTE store 0xAB to 0x103 → mem_we_o=1, mem_addr_o=0x103, mem_wdata_o=0x000000AB, mem_type_o=BYTE.
- rsn_i low during FILL, then mem_ready_i pulses after release → no mmu_wr_data_o, state IDLE, stb_empty_o=1.
- Push while full and popping in the same cycle → push refused (st_ready_o=0); count decrements by 1.
